ram64_arbiter: RTL and testbench
================================

Name: ram64_arbiter

Overview:
- Two-requester arbiter and sequencer for the 64x16 gate-level RAM (1-bit-cell RAM: E chip-enable, W/R strobes, 6-bit ADDR, 16-bit D/OUT).
- Port A is the instruction-fetch side; port B is the load/store side.
- The block latches one request, drives the RAM control lines for exactly one access cycle, and returns read data or a write acknowledge.
- Only this block may drive the RAM control lines.

Parameters:
- ADDR_W, 6, RAM address width.
- DATA_W, 16, RAM data width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = port B always wins ties.

Ports:
- CLK  in  1  clock; rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- A_REQ  in  1  port A request; held until A_GNT.
- A_WE  in  1  port A: 1 = write, 0 = read.
- A_ADDR  in  ADDR_W  port A address.
- A_WDATA  in  DATA_W  port A write data.
- A_GNT  out  1  one-cycle pulse: A request latched.
- A_DONE  out  1  one-cycle pulse: A access complete.
- A_RDATA  out  DATA_W  port A read data; valid when A_DONE is 1 and access was a read.
- B_REQ, B_WE, B_ADDR, B_WDATA, B_GNT, B_DONE, B_RDATA: same as port A, for port B.
- MEM_E  out  1  RAM enable.
- MEM_W  out  1  RAM write strobe.
- MEM_R  out  1  RAM read strobe.
- MEM_ADDR  out  ADDR_W  RAM address.
- MEM_D  out  DATA_W  RAM write data.
- MEM_OUT  in  DATA_W  RAM read data; combinational from the cells while MEM_R and MEM_E are 1.

Behaviour:
- Sequential elements:
  - All registers update on the CLK rising edge.
  - Reset is synchronous: RST_N=0 sampled at an edge forces the reset state.
- Reset state:
  - FSM = IDLE; rr_last = B, so A has first priority.
  - All GNT/DONE outputs = 0.
  - MEM_E, MEM_W, MEM_R = 0; MEM_ADDR = 0; MEM_D = 0.
  - A_RDATA, B_RDATA = 0.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - Arbitration happens here when any REQ=1.
  - At the edge the winner's WE/ADDR/WDATA are latched into cur_*, the winner's GNT is 1 for the next cycle, and the FSM goes to ACC.
  - With no REQ the FSM stays in IDLE.
- ACC (exactly 1 cycle):
  - MEM_E=1, MEM_ADDR=cur_addr.
  - MEM_W=cur_we, MEM_R=~cur_we.
  - MEM_D=cur_wdata for writes, 0 for reads.
  - Write: data commits into the RAM at the edge ending ACC.
  - Read: MEM_OUT is captured into the owner's RDATA at the edge ending ACC.
  - The FSM then goes to DONE.
- DONE (1 cycle):
  - Owner's DONE=1; MEM_E/W/R=0.
  - Arbitration also runs in DONE. If any REQ=1 the FSM goes to ACC with a new grant; otherwise it goes to IDLE.
  - Sustained throughput is therefore one access every 2 cycles.
- Control outputs (MEM_*, GNT, DONE) are registered and glitch-free; no combinational path from REQ to MEM_*.
- Arbitration:
  - Only one REQ set: that port wins.
  - Both set, FIXED_PRIO=1: B wins.
  - Both set, FIXED_PRIO=0: the port not equal to rr_last wins.
  - rr_last updates to the winner on each grant.
- Request rules:
  - The requester holds REQ and its payload stable until its GNT is sampled.
  - It may drop REQ, or present a new request, in the cycle after GNT.
  - The arbiter latches the payload at grant, so a payload change after GNT does not affect the access in progress.
  - A REQ still high in the cycle GNT is asserted is not treated as a new request; it is rearbitrated only from the following cycle.
- RDATA holds its last captured value until that port's next read completes. Writes leave RDATA unchanged.
- Only one access is outstanding at a time; A and B GNT are never 1 in the same cycle.
- Reset mid-operation: the FSM returns to IDLE at the next edge and all strobes drop. An access in ACC at the reset edge is aborted: a write does not commit because MEM_W is 0 from that edge. No DONE is issued for the aborted access.
- Address wrap: ADDR is used as-is; 63 is valid; no range checks.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles with A_REQ=1 -> no GNT, MEM_E=0, RDATA=0; first GNT to A occurs 1 cycle after RST_N=1.
- A writes 0xBEEF at addr 5, then A reads addr 5:
  - write: A_GNT, then ACC with MEM_W=1, MEM_ADDR=5, then A_DONE;
  - read: A_DONE cycle shows A_RDATA=0xBEEF.
- Simultaneous A and B read requests, held, FIXED_PRIO=0:
  - grant order is A, B, A, B;
  - no cycle has both GNT=1;
  - accesses occur every 2 cycles.
- Same stimulus with FIXED_PRIO=1 -> B is granted every arbitration until B_REQ drops; then A is granted.
- Boundary addresses:
  - B writes 0x0001 at addr 63 and 0x8000 at addr 0;
  - A reads both -> 0x0001 and 0x8000; no aliasing.
- Reset during write:
  - assert RST_N=0 while in ACC for a write of 0x1234 to addr 9 (old value 0x5555);
  - after reset, a read of addr 9 returns 0x5555;
  - no DONE is issued for the aborted write.

Source files
------------

// File: rtl/ram64_arbiter.sv
// Two-requester arbiter/sequencer for the 64x16 gate-level RAM.
// Port A (fetch) and port B (load/store) share one single-cycle RAM access slot.
module ram64_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_WDATA,
  output logic              A_GNT,
  output logic              A_DONE,
  output logic [DATA_W-1:0] A_RDATA,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_WDATA,
  output logic              B_GNT,
  output logic              B_DONE,
  output logic [DATA_W-1:0] B_RDATA,
  output logic              MEM_E,
  output logic              MEM_W,
  output logic              MEM_R,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_D,
  input  logic [DATA_W-1:0] MEM_OUT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic PORT_A  = 1'b0;
  localparam logic PORT_B  = 1'b1;
  localparam logic FIXED_B = (FIXED_PRIO != 32'sd0);

  state_t              state_q,     state_d;
  logic                rr_last_q,   rr_last_d;
  logic                owner_q,     owner_d;
  logic                cur_we_q,    cur_we_d;
  logic [ADDR_W-1:0]   cur_addr_q,  cur_addr_d;
  logic [DATA_W-1:0]   cur_wdata_q, cur_wdata_d;
  logic                a_gnt_q,     a_gnt_d;
  logic                b_gnt_q,     b_gnt_d;
  logic                a_done_q,    a_done_d;
  logic                b_done_q,    b_done_d;
  logic [DATA_W-1:0]   a_rdata_q,   a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q,   b_rdata_d;
  logic                mem_e_q,     mem_e_d;
  logic                mem_w_q,     mem_w_d;
  logic                mem_r_q,     mem_r_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_d_q,     mem_d_d;

  logic any_req;
  logic win_b;
  logic grant;

  // Winner selection: a lone requester wins; ties go to B or to the port not served last.
  always_comb begin
    any_req = A_REQ | B_REQ;
    if (A_REQ && B_REQ) begin
      win_b = FIXED_B | (rr_last_q == PORT_A);
    end else begin
      win_b = B_REQ;
    end
  end

  // Next-state and registered-output computation for the IDLE/ACC/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    owner_d     = owner_q;
    cur_we_d    = cur_we_q;
    cur_addr_d  = cur_addr_q;
    cur_wdata_d = cur_wdata_q;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_done_d    = 1'b0;
    b_done_d    = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    mem_e_d     = 1'b0;
    mem_w_d     = 1'b0;
    mem_r_d     = 1'b0;
    mem_addr_d  = '0;
    mem_d_d     = '0;
    grant       = 1'b0;

    case (state_q)
      S_IDLE: begin
        grant = any_req;
      end
      S_ACC: begin
        state_d  = S_DONE;
        a_done_d = (owner_q == PORT_A);
        b_done_d = (owner_q == PORT_B);
        if (!cur_we_q && (owner_q == PORT_A)) begin
          a_rdata_d = MEM_OUT;
        end else begin
          a_rdata_d = a_rdata_q;
        end
        if (!cur_we_q && (owner_q == PORT_B)) begin
          b_rdata_d = MEM_OUT;
        end else begin
          b_rdata_d = b_rdata_q;
        end
      end
      S_DONE: begin
        grant   = any_req;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The payload is copied at grant so later requester changes cannot disturb the access.
    if (grant) begin
      state_d     = S_ACC;
      rr_last_d   = win_b;
      owner_d     = win_b;
      cur_we_d    = win_b ? B_WE    : A_WE;
      cur_addr_d  = win_b ? B_ADDR  : A_ADDR;
      cur_wdata_d = win_b ? B_WDATA : A_WDATA;
      a_gnt_d     = ~win_b;
      b_gnt_d     = win_b;
      mem_e_d     = 1'b1;
      mem_w_d     = cur_we_d;
      mem_r_d     = ~cur_we_d;
      mem_addr_d  = cur_addr_d;
      mem_d_d     = cur_we_d ? cur_wdata_d : '0;
    end else begin
      owner_d     = owner_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      rr_last_q   <= PORT_B;
      owner_q     <= PORT_A;
      cur_we_q    <= 1'b0;
      cur_addr_q  <= '0;
      cur_wdata_q <= '0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      mem_e_q     <= 1'b0;
      mem_w_q     <= 1'b0;
      mem_r_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_d_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      owner_q     <= owner_d;
      cur_we_q    <= cur_we_d;
      cur_addr_q  <= cur_addr_d;
      cur_wdata_q <= cur_wdata_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      mem_e_q     <= mem_e_d;
      mem_w_q     <= mem_w_d;
      mem_r_q     <= mem_r_d;
      mem_addr_q  <= mem_addr_d;
      mem_d_q     <= mem_d_d;
    end
  end

  // Reset qualifies the write strobe so a write caught in ACC never reaches the cells.
  assign MEM_W    = mem_w_q & RST_N;
  assign MEM_E    = mem_e_q;
  assign MEM_R    = mem_r_q;
  assign MEM_ADDR = mem_addr_q;
  assign MEM_D    = mem_d_q;
  assign A_GNT    = a_gnt_q;
  assign B_GNT    = b_gnt_q;
  assign A_DONE   = a_done_q;
  assign B_DONE   = b_done_q;
  assign A_RDATA  = a_rdata_q;
  assign B_RDATA  = b_rdata_q;

endmodule

// File: tb/tb_ram64_arbiter.sv
// Bench for ram64_arbiter: a round-robin and a fixed-priority instance, each with its own
// behavioural RAM, checked cycle by cycle against a transaction-level reference model.
module tb_ram64_arbiter;
  localparam int AW        = 6;
  localparam int DW        = 16;
  localparam int MAX_STEPS = 4000;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic          gnt   [2][2];
  logic          done  [2][2];
  logic [DW-1:0] rdata [2][2];
  logic          mem_e    [2];
  logic          mem_w    [2];
  logic          mem_r    [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_d    [2];
  logic [DW-1:0] mem_out  [2];

  logic [DW-1:0] ram [2][64];
  bit            ram_loaded = 1'b0;

  function automatic logic [DW-1:0] init_word(input int i);
    logic [31:0] t;
    t = i * 32'd1021 + 32'h0000_3C5A;
    return t[DW-1:0];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram64_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(g)) u_dut (
      .CLK(clk), .RST_N(rst_n),
      .A_REQ(req[g][0]), .A_WE(we[g][0]), .A_ADDR(addr[g][0]), .A_WDATA(wdata[g][0]),
      .A_GNT(gnt[g][0]), .A_DONE(done[g][0]), .A_RDATA(rdata[g][0]),
      .B_REQ(req[g][1]), .B_WE(we[g][1]), .B_ADDR(addr[g][1]), .B_WDATA(wdata[g][1]),
      .B_GNT(gnt[g][1]), .B_DONE(done[g][1]), .B_RDATA(rdata[g][1]),
      .MEM_E(mem_e[g]), .MEM_W(mem_w[g]), .MEM_R(mem_r[g]),
      .MEM_ADDR(mem_addr[g]), .MEM_D(mem_d[g]), .MEM_OUT(mem_out[g])
    );
    assign mem_out[g] = (mem_e[g] && mem_r[g]) ? ram[g][mem_addr[g]] : '0;
  end

  // RAM cells: loaded once, then written at any edge where E and W are high.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 64; i++) ram[d][i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++)
        if (mem_e[d] && mem_w[d]) ram[d][mem_addr[d]] <= mem_d[d];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state: expected memory image, read-data latches, pending access.
  bit            m_acc   [2];
  bit            m_owner [2];
  bit            m_last  [2];
  txn_t          m_cur   [2];
  logic [DW-1:0] shadow    [2][64];
  logic [DW-1:0] exp_rdata [2][2];
  int            glog[$];
  int            cyc = 0;

  // Requesters: q = dut*2 + port.
  txn_t rq [4][$];
  bit   presenting [4];
  bit   gseen      [4];
  bit   eager = 1'b1;

  task automatic drive_port(input int q);
    int d;
    int p;
    d = q / 2;
    p = q % 2;
    req[d][p] = presenting[q];
    if (presenting[q]) begin
      {we[d][p], addr[d][p], wdata[d][p]} = rq[q][0];
    end else begin
      we[d][p]    = 1'($urandom);
      addr[d][p]  = AW'($urandom);
      wdata[d][p] = DW'($urandom);
    end
  endtask

  task automatic update_requesters();
    int d;
    int p;
    for (int q = 0; q < 4; q++) begin
      d = q / 2;
      p = q % 2;
      if (gseen[q]) begin
        if (rq[q].size() > 0) void'(rq[q].pop_front());
        gseen[q]      = 1'b0;
        presenting[q] = 1'b0;
      end
      if (presenting[q] && gnt[d][p] === 1'b1) gseen[q] = 1'b1;
      else if (!presenting[q] && rq[q].size() > 0 && (eager || $urandom_range(0, 3) != 0))
        presenting[q] = 1'b1;
      drive_port(q);
    end
  endtask

  task automatic clear_requesters();
    for (int q = 0; q < 4; q++) begin
      rq[q].delete();
      presenting[q] = 1'b0;
      gseen[q]      = 1'b0;
      drive_port(q);
    end
  endtask

  task automatic step();
    bit   p_rst;
    bit   p_req [2][2];
    txn_t p_pay [2][2];
    bit   eg [2];
    bit   ed [2];
    bit   w;
    bit   was_acc;
    p_rst = rst_n;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        p_req[d][p] = req[d][p];
        p_pay[d][p] = {we[d][p], addr[d][p], wdata[d][p]};
      end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      eg[0] = 1'b0; eg[1] = 1'b0; ed[0] = 1'b0; ed[1] = 1'b0;
      was_acc  = m_acc[d];
      m_acc[d] = 1'b0;
      if (!p_rst) begin
        m_last[d] = 1'b1;
        exp_rdata[d][0] = '0;
        exp_rdata[d][1] = '0;
      end else if (was_acc) begin
        ed[m_owner[d]] = 1'b1;
        if (m_cur[d].we) shadow[d][m_cur[d].addr] = m_cur[d].wdata;
        else exp_rdata[d][m_owner[d]] = shadow[d][m_cur[d].addr];
      end else if (p_req[d][0] || p_req[d][1]) begin
        if (p_req[d][0] && p_req[d][1]) w = (d == 1) ? 1'b1 : ~m_last[d];
        else w = p_req[d][1];
        eg[w] = 1'b1;
        m_acc[d] = 1'b1;
        m_owner[d] = w;
        m_last[d] = w;
        m_cur[d] = p_pay[d][w];
        glog.push_back(cyc * 4 + d * 2 + int'(w));
      end
      chk_eq($sformatf("d%0d_a_gnt", d),  32'(gnt[d][0]),  32'(eg[0]));
      chk_eq($sformatf("d%0d_b_gnt", d),  32'(gnt[d][1]),  32'(eg[1]));
      chk_eq($sformatf("d%0d_a_done", d), 32'(done[d][0]), 32'(ed[0]));
      chk_eq($sformatf("d%0d_b_done", d), 32'(done[d][1]), 32'(ed[1]));
      chk_eq($sformatf("d%0d_mem_e", d),  32'(mem_e[d]),   32'(m_acc[d]));
      chk_eq($sformatf("d%0d_mem_w", d),  32'(mem_w[d]),   32'(m_acc[d] & m_cur[d].we));
      chk_eq($sformatf("d%0d_mem_r", d),  32'(mem_r[d]),   32'(m_acc[d] & ~m_cur[d].we));
      if (m_acc[d]) begin
        chk_eq($sformatf("d%0d_mem_addr", d), 32'(mem_addr[d]), 32'(m_cur[d].addr));
        chk_eq($sformatf("d%0d_mem_d", d), 32'(mem_d[d]),
               32'(m_cur[d].we ? m_cur[d].wdata : 16'h0000));
      end else if (!p_rst) begin
        chk_eq($sformatf("d%0d_rst_addr", d), 32'(mem_addr[d]), 32'd0);
        chk_eq($sformatf("d%0d_rst_d", d), 32'(mem_d[d]), 32'd0);
      end
      chk_eq($sformatf("d%0d_a_rdata", d), 32'(rdata[d][0]), 32'(exp_rdata[d][0]));
      chk_eq($sformatf("d%0d_b_rdata", d), 32'(rdata[d][1]), 32'(exp_rdata[d][1]));
    end
    update_requesters();
  endtask

  function automatic bit all_idle();
    bit r;
    r = !m_acc[0] && !m_acc[1];
    for (int q = 0; q < 4; q++) if (rq[q].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!all_idle() && n < MAX_STEPS) begin
      step();
      n++;
    end
    chk_eq({tag, "_drain"}, 32'(all_idle()), 32'd1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    clear_requesters();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int   seq [2][$];
    int   cy  [2][$];
    int   e;
    int   n;
    txn_t t;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) shadow[d][i] = init_word(i);
      exp_rdata[d][0] = '0;
      exp_rdata[d][1] = '0;
      m_acc[d] = 1'b0; m_last[d] = 1'b1; m_owner[d] = 1'b0; m_cur[d] = '0;
    end
    clear_requesters();

    // Reset held with A requesting; first grant one cycle after release.
    for (int d = 0; d < 2; d++) begin
      rq[d * 2].push_back({1'b1, 6'd5, 16'hBEEF});
      presenting[d * 2] = 1'b1;
      drive_port(d * 2);
    end
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk_eq("first_gnt_d0", 32'(gnt[0][0]), 32'd1);
    chk_eq("first_gnt_d1", 32'(gnt[1][0]), 32'd1);
    drain("wr5");
    for (int d = 0; d < 2; d++) rq[d * 2].push_back({1'b0, 6'd5, 16'h0000});
    drain("rd5");
    chk_eq("rd5_d0", 32'(rdata[0][0]), 32'h0000_BEEF);
    chk_eq("rd5_d1", 32'(rdata[1][0]), 32'h0000_BEEF);

    // Both ports hold read requests from reset: alternation vs fixed B priority.
    pulse_reset();
    glog.delete();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        rq[d * 2].push_back({1'b0, 6'(10 + i), 16'h0000});
        rq[d * 2 + 1].push_back({1'b0, 6'(20 + i), 16'h0000});
      end
    drain("prio");
    foreach (glog[i]) begin
      e = glog[i];
      seq[(e / 2) % 2].push_back(e % 2);
      cy[(e / 2) % 2].push_back(e / 4);
    end
    for (int d = 0; d < 2; d++) begin
      chk_eq($sformatf("prio_count_d%0d", d), 32'(seq[d].size()), 32'd8);
      for (int i = 0; i < seq[d].size() && i < 8; i++) begin
        chk_eq($sformatf("prio_order_d%0d_%0d", d, i), 32'(seq[d][i]),
               (d == 0) ? 32'(i % 2) : ((i < 4) ? 32'd1 : 32'd0));
        if (i > 0) chk_eq($sformatf("prio_gap_d%0d_%0d", d, i), 32'(cy[d][i] - cy[d][i - 1]), 32'd2);
      end
    end

    // Boundary addresses written by B, read back by A.
    for (int d = 0; d < 2; d++) begin
      rq[d * 2 + 1].push_back({1'b1, 6'd63, 16'h0001});
      rq[d * 2 + 1].push_back({1'b1, 6'd0,  16'h8000});
    end
    drain("bnd_wr");
    for (int d = 0; d < 2; d++) rq[d * 2].push_back({1'b0, 6'd63, 16'h0000});
    drain("bnd_rd63");
    chk_eq("bnd63_d0", 32'(rdata[0][0]), 32'h0000_0001);
    chk_eq("bnd63_d1", 32'(rdata[1][0]), 32'h0000_0001);
    for (int d = 0; d < 2; d++) rq[d * 2].push_back({1'b0, 6'd0, 16'h0000});
    drain("bnd_rd0");
    chk_eq("bnd0_d0", 32'(rdata[0][0]), 32'h0000_8000);
    chk_eq("bnd0_d1", 32'(rdata[1][0]), 32'h0000_8000);

    // Reset while a write sits in ACC: write must not land, no DONE for it.
    rq[0].push_back({1'b1, 6'd9, 16'h5555});
    drain("pre_abort");
    rq[0].push_back({1'b1, 6'd9, 16'h1234});
    n = 0;
    while (gnt[0][0] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk_eq("abort_gnt_seen", 32'(gnt[0][0]), 32'd1);
    rst_n = 1'b0;
    clear_requesters();
    step();
    chk_eq("abort_no_done", 32'(done[0][0]), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    rq[0].push_back({1'b0, 6'd9, 16'h0000});
    drain("post_abort");
    chk_eq("abort_rd9", 32'(rdata[0][0]), 32'h0000_5555);

    // Randomized mixed traffic with random request gaps.
    eager = 1'b0;
    for (int i = 0; i < 200; i++) begin
      t.we    = 1'($urandom);
      t.addr  = AW'($urandom);
      t.wdata = DW'($urandom);
      rq[$urandom_range(0, 3)].push_back(t);
    end
    drain("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
